// File: rtl/nvmem_reset_ctrl_pkg.sv
// Shared definitions for the NVMEM write-rate monitor and its reset responder.
package nvmem_pkg;

  localparam int unsigned      ADDR_W          = 16;
  localparam logic [ADDR_W-1:0] NVMEM_START_DEF = 16'hE000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_COOLDOWN,
    ST_LOCKED
  } state_e;

  // Counter width large enough to hold the longer of the two intervals.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nvmem_reset_ctrl_if.sv
// Bus taps and status outputs shared between the monitor side and the reset responder.
interface nvmem_reset_ctrl_if;
  import nvmem_pkg::*;

  logic              viol_req;
  logic [ADDR_W-1:0] data_addr;
  logic              data_wen;
  logic              dev_reset;
  logic              nv_wen_gated;
  logic              busy;
  logic              locked;
  logic [7:0]        viol_count;
  logic [ADDR_W-1:0] last_addr;

  modport master (
    output viol_req, data_addr, data_wen,
    input  dev_reset, nv_wen_gated, busy, locked, viol_count, last_addr
  );

  modport slave (
    input  viol_req, data_addr, data_wen,
    output dev_reset, nv_wen_gated, busy, locked, viol_count, last_addr
  );

endinterface

// File: rtl/nvmem_down_counter.sv
// Loadable down-counter with zero flag; times both the hold and cooldown intervals.
module nvmem_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nvmem_reset_ctrl.sv
// Turns NVMEM write-rate violations into a timed device reset, cooldown and lockout.
// Optional macro NVMEM_WGATE_EN blocks NVMEM writes while the device is held in reset.
module nvmem_reset_ctrl
  import nvmem_pkg::*;
#(
  parameter int unsigned       RESET_HOLD     = 16,
  parameter int unsigned       COOLDOWN       = 64,
  parameter int unsigned       MAX_VIOLATIONS = 3,
  parameter logic [ADDR_W-1:0] NVMEM_START    = NVMEM_START_DEF
) (
  input  logic                clk,
  input  logic                reset,
  nvmem_reset_ctrl_if.slave   bus
);

  localparam int unsigned CW = cnt_width(RESET_HOLD, COOLDOWN);

  state_e            r_state;
  state_e            w_next;
  logic              r_viol_req_q;
  logic [ADDR_W-1:0] r_nv_addr_q;
  logic [ADDR_W-1:0] r_last_addr;
  logic [7:0]        r_viol_count;
  logic              r_dev_reset;

  logic              w_trig;
  logic              w_nv_wr;
  logic              w_accept;
  logic              w_at_max;
  logic              w_cnt_zero;
  logic              w_load;
  logic [CW-1:0]     w_load_val;
  logic              w_dec;
  logic              w_busy;
  logic              w_locked;
  logic              w_gated;

  assign w_trig   = bus.viol_req && !r_viol_req_q;
  assign w_nv_wr  = bus.data_wen && (bus.data_addr >= NVMEM_START);
  assign w_accept = (r_state == ST_IDLE) && w_trig;
  assign w_at_max = (r_viol_count == 8'(MAX_VIOLATIONS));

  nvmem_down_counter #(.WIDTH(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_next     = ST_HOLD;
          w_load     = 1'b1;
          w_load_val = CW'(RESET_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (!w_cnt_zero) begin
          w_dec = 1'b1;
        end else if (w_at_max) begin
          w_next = ST_LOCKED;
        end else if (COOLDOWN == 0) begin
          w_next = ST_IDLE;
        end else begin
          w_next     = ST_COOLDOWN;
          w_load     = 1'b1;
          w_load_val = CW'(COOLDOWN - 1);
        end
      end
      ST_COOLDOWN: begin
        if (w_cnt_zero) begin
          w_next = ST_IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_LOCKED: w_next = ST_LOCKED;
      default:   w_next = ST_IDLE;
    endcase
  end

  // dev_reset is a flop fed from the next state so it rises on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_viol_req_q <= 1'b0;
      r_nv_addr_q  <= '0;
      r_last_addr  <= '0;
      r_viol_count <= '0;
      r_dev_reset  <= 1'b0;
    end else begin
      r_viol_req_q <= bus.viol_req;
      r_dev_reset  <= (w_next == ST_HOLD) || (w_next == ST_LOCKED);
      if (w_nv_wr) begin
        r_nv_addr_q <= bus.data_addr;
      end
      if (w_accept) begin
        r_viol_count <= r_viol_count + 8'd1;
        r_last_addr  <= w_nv_wr ? bus.data_addr : r_nv_addr_q;
      end
    end
  end

  always_comb begin
    w_busy   = (r_state == ST_HOLD) || (r_state == ST_COOLDOWN);
    w_locked = (r_state == ST_LOCKED);
`ifdef NVMEM_WGATE_EN
    w_gated  = bus.data_wen &&
               !((bus.data_addr >= NVMEM_START) &&
                 ((r_state == ST_HOLD) || (r_state == ST_LOCKED)));
`else
    w_gated  = bus.data_wen;
`endif
  end

  assign bus.dev_reset    = r_dev_reset;
  assign bus.busy         = w_busy;
  assign bus.locked       = w_locked;
  assign bus.viol_count   = r_viol_count;
  assign bus.last_addr    = r_last_addr;
  assign bus.nv_wen_gated = w_gated;

endmodule

// File: tb/tb_nvmem_reset_ctrl.sv
// Scoreboard bench for nvmem_reset_ctrl: timestamp-based reference model, directed plus random stimulus.
module tb_nvmem_reset_ctrl;
  import nvmem_pkg::*;

  localparam int unsigned H     = 4;
  localparam int unsigned C     = 8;
  localparam int unsigned MAXV  = 3;
  localparam logic [15:0] START = 16'hE000;

  typedef struct packed {
    logic        dev;
    logic        busy;
    logic        lck;
    logic        gated;
    logic [7:0]  cnt;
    logic [15:0] last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nvmem_reset_ctrl_if bus();

  nvmem_reset_ctrl #(
    .RESET_HOLD     (H),
    .COOLDOWN       (C),
    .MAX_VIOLATIONS (MAXV),
    .NVMEM_START    (START)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a violation accepted at edge k resets the device for cycles
  // k..k+H-1, keeps it busy until k+H+C-1, or locks it from k+H on the last allowed one.
  int          k         = -1;
  int          hold_end  = -1;
  int          busy_end  = -1;
  int          lock_from = 0;
  bit          lockf     = 0;
  int          m_count   = 0;
  logic [15:0] m_last    = '0;
  logic [15:0] m_nvq     = '0;
  bit          m_rq      = 0;

  task automatic model_edge();
    bit idle;
    bit nvw;
    k++;
    nvw = bus.data_wen && (bus.data_addr >= START);
    if (rst) begin
      m_count  = 0;
      m_last   = '0;
      m_nvq    = '0;
      m_rq     = 0;
      hold_end = -1;
      busy_end = -1;
      lockf    = 0;
    end else begin
      idle = !lockf && (k - 1 > busy_end);
      if (bus.viol_req && !m_rq && idle) begin
        m_count++;
        m_last   = nvw ? bus.data_addr : m_nvq;
        hold_end = k + int'(H) - 1;
        if (m_count == int'(MAXV)) begin
          lockf     = 1;
          lock_from = k + int'(H);
          busy_end  = hold_end;
        end else begin
          busy_end = hold_end + int'(C);
        end
      end
      if (nvw) m_nvq = bus.data_addr;
      m_rq = bus.viol_req;
    end
  endtask

  task automatic cyc(input logic r, input logic req, input logic wen, input logic [15:0] addr);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst           = r;
    bus.viol_req  = req;
    bus.data_wen  = wen;
    bus.data_addr = addr;
    e.lck  = lockf && (k >= lock_from);
    e.dev  = (k <= hold_end) || e.lck;
    e.busy = (k <= busy_end);
    e.cnt  = 8'(m_count);
    e.last = m_last;
`ifdef NVMEM_WGATE_EN
    e.gated = wen && !((addr >= START) && e.dev);
`else
    e.gated = wen;
`endif
    sb.push_back(e);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic pulse();
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dev_reset",    16'(bus.dev_reset),    16'(e.dev));
        chk("busy",         16'(bus.busy),         16'(e.busy));
        chk("locked",       16'(bus.locked),       16'(e.lck));
        chk("nv_wen_gated", 16'(bus.nv_wen_gated), 16'(e.gated));
        chk("viol_count",   16'(bus.viol_count),   16'(e.cnt));
        chk("last_addr",    bus.last_addr,         e.last);
      end
    end
  end

  logic [15:0] edge_addrs [4] = '{16'hDFFF, 16'hE000, 16'hFFFF, 16'h0000};

  initial begin : stim
    logic        req;
    logic [15:0] a;
    rst           = 1'b1;
    bus.viol_req  = 1'b0;
    bus.data_wen  = 1'b0;
    bus.data_addr = '0;

    // Single violation with hold and cooldown
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    idle_n(8);
    pulse();
    idle_n(20);

    // Address capture ignores writes below NVMEM_START
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    idle_n(3);
    cyc(1'b0, 1'b0, 1'b1, 16'hE123);
    idle_n(1);
    cyc(1'b0, 1'b0, 1'b1, 16'h1000);
    idle_n(1);
    pulse();
    idle_n(14);

    // Same-cycle NVMEM write is captured directly
    cyc(1'b0, 1'b1, 1'b1, 16'hE456);
    idle_n(14);

    // Held request counts once; then fresh edges up to lockout
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    idle_n(2);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    idle_n(4);
    pulse();
    idle_n(14);
    pulse();
    idle_n(10);
    for (int i = 0; i < 3; i++) begin
      pulse();
      idle_n(6);
    end
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    idle_n(3);

    // Reset in the middle of HOLD
    pulse();
    idle_n(2);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    idle_n(3);

    // Write gating during HOLD, high and low addresses
    pulse();
    cyc(1'b0, 1'b0, 1'b1, 16'hF000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0100);
    idle_n(14);

    // Random traffic with occasional resets
    req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) req = ~req;
      case ($urandom_range(0, 3))
        0:       a = edge_addrs[$urandom_range(0, 3)];
        1:       a = 16'($urandom_range(32'hE000, 32'hFFFF));
        default: a = 16'($urandom_range(32'h0000, 32'hDFFF));
      endcase
      cyc(($urandom_range(0, 249) == 0), req, 1'($urandom_range(0, 1)), a);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
